// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the TLB maintenance engine.
//   - operation codes and INVTLB op codes
//   - TLB entry layout (89 bits, MSB first) as a packed struct plus bit offsets
//   - CSR field positions used by TLBSRCH/TLBRD/TLBWR/TLBFILL
//   - engine state encoding and an ELO packing helper
package tlb_pkg;

   typedef enum logic [2:0] {
      OpSrch = 3'd0,
      OpRd   = 3'd1,
      OpWr   = 3'd2,
      OpFill = 3'd3,
      OpInv  = 3'd4
   } op_code_e;

   localparam logic [4:0] INV_ALL0       = 5'd0;
   localparam logic [4:0] INV_ALL1       = 5'd1;
   localparam logic [4:0] INV_G          = 5'd2;
   localparam logic [4:0] INV_NG         = 5'd3;
   localparam logic [4:0] INV_NG_ASID    = 5'd4;
   localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
   localparam logic [4:0] INV_G_ASID_VA  = 5'd6;
   localparam logic [4:0] INV_OP_MAX     = 5'd6;

   localparam int unsigned ENTRY_W = 89;

   // Bit offsets inside the packed entry.
   localparam int unsigned ENT_E_BIT     = 88;
   localparam int unsigned ENT_VPPN_LSB  = 69;
   localparam int unsigned ENT_PS_LSB    = 63;
   localparam int unsigned ENT_ASID_LSB  = 53;
   localparam int unsigned ENT_G_BIT     = 52;
   localparam int unsigned ENT_PPN0_LSB  = 32;
   localparam int unsigned ENT_PLV0_LSB  = 30;
   localparam int unsigned ENT_MAT0_LSB  = 28;
   localparam int unsigned ENT_D0_BIT    = 27;
   localparam int unsigned ENT_V0_BIT    = 26;
   localparam int unsigned ENT_PPN1_LSB  = 6;
   localparam int unsigned ENT_PLV1_LSB  = 4;
   localparam int unsigned ENT_MAT1_LSB  = 2;
   localparam int unsigned ENT_D1_BIT    = 1;
   localparam int unsigned ENT_V1_BIT    = 0;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      logic [19:0] ppn0;
      logic [1:0]  plv0;
      logic [1:0]  mat0;
      logic        d0;
      logic        v0;
      logic [19:0] ppn1;
      logic [1:0]  plv1;
      logic [1:0]  mat1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   // CSR field positions.
   localparam int unsigned TLBIDX_NE       = 31;
   localparam int unsigned TLBIDX_PS_LSB   = 24;
   localparam int unsigned TLBEHI_VPPN_LSB = 13;
   localparam int unsigned ELO_V           = 0;
   localparam int unsigned ELO_D           = 1;
   localparam int unsigned ELO_PLV_LSB     = 2;
   localparam int unsigned ELO_MAT_LSB     = 4;
   localparam int unsigned ELO_G           = 6;
   localparam int unsigned ELO_PPN_LSB     = 8;

   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StWalk = 2'd2
   } state_e;

   function automatic logic [31:0] elo_pack(input logic [19:0] ppn, input logic g,
                                            input logic [1:0] mat, input logic [1:0] plv,
                                            input logic d, input logic v);
      return {4'b0, ppn, 1'b0, g, mat, plv, d, v};
   endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// tlb_inv_match: combinational INVTLB match predicate.
// Ports:
//   entry    in  89  TLB entry under test
//   inv_op   in  5   INVTLB op field
//   inv_asid in  10  ASID operand
//   inv_va   in  32  VA operand
//   match    out 1   entry is valid and selected by inv_op (0 for op > 6)
module tlb_inv_match
   import tlb_pkg::*;
(
   input  logic [ENTRY_W-1:0] entry,
   input  logic [4:0]         inv_op,
   input  logic [9:0]         inv_asid,
   input  logic [31:0]        inv_va,
   output logic               match
);

   tlb_entry_t ent;
   logic       asid_hit;
   logic       va_hit;
   logic       sel;
   logic       unused_va;

   assign ent       = entry;
   assign unused_va = ^inv_va[12:0];

   always_comb begin
      asid_hit = (ent.asid == inv_asid);
      // 4 MB pages (ps=21) only compare the upper 10 bits of VPPN.
      if (ent.ps == 6'd21) begin
         va_hit = (ent.vppn[18:9] == inv_va[31:22]);
      end else begin
         va_hit = (ent.vppn == inv_va[31:13]);
      end

      sel = 1'b0;
      case (inv_op)
         INV_ALL0, INV_ALL1: sel = 1'b1;
         INV_G:              sel = ent.g;
         INV_NG:             sel = ~ent.g;
         INV_NG_ASID:        sel = ~ent.g & asid_hit;
         INV_NG_ASID_VA:     sel = ~ent.g & asid_hit & va_hit;
         INV_G_ASID_VA:      sel = (ent.g | asid_hit) & va_hit;
         default:            sel = 1'b0;
      endcase

      match = ent.e & sel;
   end

endmodule

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: multi-cycle TLB maintenance engine (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid/op_ready        request handshake from WB; op_code, inv_op, inv_asid, inv_va
//   op_done/op_err/tlb_flush completion pulse, INE for INVTLB op > 6, pipeline refetch
//   csr_*                    current TLBIDX/TLBEHI/TLBELO0/TLBELO1/ASID, ESTAT.Ecode
//   we/w_index/w_entry       TLB write port
//   r_index/r_entry          combinational TLB read port
//   s_vppn/s_va_bit12/s_asid search request; s_found/s_index search result
//   rd_we/srch_we            CSR write strobes; *_wdata CSR write values
// Build option: define TLB_FILL_LFSR_EN to pick the TLBFILL index from a free-running
// 16-bit LFSR instead of the round-robin fill pointer.
module tlb_ctrl
   import tlb_pkg::*;
#(
   parameter int unsigned TLBNUM = 16,
   parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [2:0]         op_code,
   input  logic [4:0]         inv_op,
   input  logic [9:0]         inv_asid,
   input  logic [31:0]        inv_va,
   output logic               op_done,
   output logic               op_err,
   output logic               tlb_flush,
   input  logic [31:0]        csr_tlbidx,
   input  logic [31:0]        csr_tlbehi,
   input  logic [31:0]        csr_tlbelo0,
   input  logic [31:0]        csr_tlbelo1,
   input  logic [31:0]        csr_asid,
   input  logic [5:0]         csr_estat_ecode,
   output logic               we,
   output logic [IDXW-1:0]    w_index,
   output logic [ENTRY_W-1:0] w_entry,
   output logic [IDXW-1:0]    r_index,
   input  logic [ENTRY_W-1:0] r_entry,
   output logic [18:0]        s_vppn,
   output logic               s_va_bit12,
   output logic [9:0]         s_asid,
   input  logic               s_found,
   input  logic [IDXW-1:0]    s_index,
   output logic               rd_we,
   output logic               srch_we,
   output logic [31:0]        tlbidx_wdata,
   output logic [31:0]        tlbehi_wdata,
   output logic [31:0]        tlbelo0_wdata,
   output logic [31:0]        tlbelo1_wdata,
   output logic [31:0]        asid_wdata
);

   state_e          state_q, state_d;
   logic [2:0]      op_q;
   logic [4:0]      inv_op_q;
   logic [9:0]      inv_asid_q;
   logic [31:0]     inv_va_q;
   logic [IDXW-1:0] walk_q;
   logic [IDXW-1:0] fill_idx;
   logic            walk_last;
   logic            inv_hit;
   tlb_entry_t      rd_ent;
   tlb_entry_t      wr_ent;
   tlb_entry_t      clr_ent;
   logic            unused_csr;

   assign unused_csr = ^{csr_tlbehi[11:0], csr_tlbelo0[31:28], csr_tlbelo0[7],
                         csr_tlbelo1[31:28], csr_tlbelo1[7]};

   assign rd_ent    = r_entry;
   assign walk_last = (walk_q == IDXW'(TLBNUM - 1));

   tlb_inv_match u_inv_match (
      .entry    (r_entry),
      .inv_op   (inv_op_q),
      .inv_asid (inv_asid_q),
      .inv_va   (inv_va_q),
      .match    (inv_hit)
   );

   // Entry image for TLBWR/TLBFILL and the invalidated copy written back during the walk.
   always_comb begin
      // TLB refill handler always writes a valid entry regardless of NE.
      wr_ent.e    = (csr_estat_ecode == ECODE_TLBR) ? 1'b1 : ~csr_tlbidx[TLBIDX_NE];
      wr_ent.vppn = csr_tlbehi[31:TLBEHI_VPPN_LSB];
      wr_ent.ps   = csr_tlbidx[TLBIDX_PS_LSB +: 6];
      wr_ent.asid = csr_asid[9:0];
      wr_ent.g    = csr_tlbelo0[ELO_G] & csr_tlbelo1[ELO_G];
      wr_ent.ppn0 = csr_tlbelo0[ELO_PPN_LSB +: 20];
      wr_ent.plv0 = csr_tlbelo0[ELO_PLV_LSB +: 2];
      wr_ent.mat0 = csr_tlbelo0[ELO_MAT_LSB +: 2];
      wr_ent.d0   = csr_tlbelo0[ELO_D];
      wr_ent.v0   = csr_tlbelo0[ELO_V];
      wr_ent.ppn1 = csr_tlbelo1[ELO_PPN_LSB +: 20];
      wr_ent.plv1 = csr_tlbelo1[ELO_PLV_LSB +: 2];
      wr_ent.mat1 = csr_tlbelo1[ELO_MAT_LSB +: 2];
      wr_ent.d1   = csr_tlbelo1[ELO_D];
      wr_ent.v1   = csr_tlbelo1[ELO_V];

      clr_ent   = rd_ent;
      clr_ent.e = 1'b0;
   end

`ifdef TLB_FILL_LFSR_EN
   logic [15:0] lfsr_q;

   // Fibonacci LFSR, taps 16/14/13/11.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign fill_idx = lfsr_q[IDXW-1:0];
`else
   logic [IDXW-1:0] fill_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q <= '0;
      end else if (state_q == StExec && op_q == OpFill) begin
         fill_q <= fill_q + 1'b1;
      end
   end

   assign fill_idx = fill_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         op_q       <= '0;
         inv_op_q   <= '0;
         inv_asid_q <= '0;
         inv_va_q   <= '0;
         walk_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && op_valid) begin
            op_q       <= op_code;
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_va_q   <= inv_va;
         end
         if (state_q == StWalk) begin
            walk_q <= walk_last ? '0 : walk_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      op_ready      = 1'b0;
      op_done       = 1'b0;
      op_err        = 1'b0;
      tlb_flush     = 1'b0;
      we            = 1'b0;
      w_index       = '0;
      w_entry       = '0;
      r_index       = '0;
      s_vppn        = '0;
      s_va_bit12    = 1'b0;
      s_asid        = '0;
      rd_we         = 1'b0;
      srch_we       = 1'b0;
      tlbidx_wdata  = '0;
      tlbehi_wdata  = '0;
      tlbelo0_wdata = '0;
      tlbelo1_wdata = '0;
      asid_wdata    = '0;

      // Reset wins combinationally so an aborted walk issues no write on the reset edge.
      if (rst) begin
         op_ready = 1'b1;
         state_d  = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               op_ready = 1'b1;
               if (op_valid) begin
                  if (op_code == OpInv && inv_op <= INV_OP_MAX) begin
                     state_d = StWalk;
                  end else begin
                     state_d = StExec;
                  end
               end
            end

            StExec: begin
               op_done = 1'b1;
               state_d = StIdle;
               case (op_q)
                  OpSrch: begin
                     s_vppn     = csr_tlbehi[31:TLBEHI_VPPN_LSB];
                     s_va_bit12 = csr_tlbehi[12];
                     s_asid     = csr_asid[9:0];
                     srch_we    = 1'b1;
                     if (s_found) begin
                        tlbidx_wdata = {1'b0, csr_tlbidx[30:IDXW], s_index};
                     end else begin
                        tlbidx_wdata = {1'b1, csr_tlbidx[30:0]};
                     end
                  end
                  OpRd: begin
                     r_index = csr_tlbidx[IDXW-1:0];
                     rd_we   = 1'b1;
                     if (rd_ent.e) begin
                        tlbidx_wdata  = {1'b0, csr_tlbidx[30], rd_ent.ps, csr_tlbidx[23:0]};
                        tlbehi_wdata  = {rd_ent.vppn, 13'b0};
                        tlbelo0_wdata = elo_pack(rd_ent.ppn0, rd_ent.g, rd_ent.mat0,
                                                 rd_ent.plv0, rd_ent.d0, rd_ent.v0);
                        tlbelo1_wdata = elo_pack(rd_ent.ppn1, rd_ent.g, rd_ent.mat1,
                                                 rd_ent.plv1, rd_ent.d1, rd_ent.v1);
                        asid_wdata    = {csr_asid[31:10], rd_ent.asid};
                     end else begin
                        tlbidx_wdata = 32'h8000_0000;
                     end
                  end
                  OpWr: begin
                     we        = 1'b1;
                     w_index   = csr_tlbidx[IDXW-1:0];
                     w_entry   = wr_ent;
                     tlb_flush = 1'b1;
                  end
                  OpFill: begin
                     we        = 1'b1;
                     w_index   = fill_idx;
                     w_entry   = wr_ent;
                     tlb_flush = 1'b1;
                  end
                  OpInv: begin
                     // Only INVTLB with an undefined op reaches EXEC.
                     op_err = 1'b1;
                  end
                  default: ;
               endcase
            end

            StWalk: begin
               r_index = walk_q;
               we      = inv_hit;
               w_index = walk_q;
               w_entry = clr_ent;
               if (walk_last) begin
                  op_done   = 1'b1;
                  tlb_flush = 1'b1;
                  state_d   = StIdle;
               end
            end

            default: state_d = StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: directed self-checking bench for tlb_ctrl with a behavioural 16-entry TLB.
module tb_tlb_ctrl;

   localparam int TLBNUM = 16;
   localparam int IDXW   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op_code;
   logic [4:0]        inv_op;
   logic [9:0]        inv_asid;
   logic [31:0]       inv_va;
   logic              op_done;
   logic              op_err;
   logic              tlb_flush;
   logic [31:0]       csr_tlbidx;
   logic [31:0]       csr_tlbehi;
   logic [31:0]       csr_tlbelo0;
   logic [31:0]       csr_tlbelo1;
   logic [31:0]       csr_asid;
   logic [5:0]        csr_estat_ecode;
   logic              we;
   logic [IDXW-1:0]   w_index;
   logic [88:0]       w_entry;
   logic [IDXW-1:0]   r_index;
   logic [88:0]       r_entry;
   logic [18:0]       s_vppn;
   logic              s_va_bit12;
   logic [9:0]        s_asid;
   logic              s_found;
   logic [IDXW-1:0]   s_index;
   logic              rd_we;
   logic              srch_we;
   logic [31:0]       tlbidx_wdata;
   logic [31:0]       tlbehi_wdata;
   logic [31:0]       tlbelo0_wdata;
   logic [31:0]       tlbelo1_wdata;
   logic [31:0]       asid_wdata;

   logic [88:0] mem     [TLBNUM];
   logic [88:0] pre_mem [TLBNUM];
   logic [88:0] exp_mem [TLBNUM];
   logic        pre_en;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tlb_ctrl #(
      .TLBNUM (TLBNUM),
      .IDXW   (IDXW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .op_valid        (op_valid),
      .op_ready        (op_ready),
      .op_code         (op_code),
      .inv_op          (inv_op),
      .inv_asid        (inv_asid),
      .inv_va          (inv_va),
      .op_done         (op_done),
      .op_err          (op_err),
      .tlb_flush       (tlb_flush),
      .csr_tlbidx      (csr_tlbidx),
      .csr_tlbehi      (csr_tlbehi),
      .csr_tlbelo0     (csr_tlbelo0),
      .csr_tlbelo1     (csr_tlbelo1),
      .csr_asid        (csr_asid),
      .csr_estat_ecode (csr_estat_ecode),
      .we              (we),
      .w_index         (w_index),
      .w_entry         (w_entry),
      .r_index         (r_index),
      .r_entry         (r_entry),
      .s_vppn          (s_vppn),
      .s_va_bit12      (s_va_bit12),
      .s_asid          (s_asid),
      .s_found         (s_found),
      .s_index         (s_index),
      .rd_we           (rd_we),
      .srch_we         (srch_we),
      .tlbidx_wdata    (tlbidx_wdata),
      .tlbehi_wdata    (tlbehi_wdata),
      .tlbelo0_wdata   (tlbelo0_wdata),
      .tlbelo1_wdata   (tlbelo1_wdata),
      .asid_wdata      (asid_wdata)
   );

   // Behavioural TLB: bulk preload or single-entry write, combinational read.
   always @(posedge clk) begin
      if (pre_en) begin
         for (int i = 0; i < TLBNUM; i++) mem[i] <= pre_mem[i];
      end else if (we) begin
         mem[w_index] <= w_entry;
      end
   end
   assign r_entry = mem[r_index];

   task automatic chk(input string tag, input logic [88:0] got, input logic [88:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Entry with plv=0, mat=1, d=1, v=1 in both halves.
   function automatic logic [88:0] mk(input logic e, input logic [18:0] vppn,
                                      input logic [5:0] ps, input logic [9:0] asid,
                                      input logic g, input logic [19:0] p0,
                                      input logic [19:0] p1);
      return {e, vppn, ps, asid, g, p0, 2'd0, 2'd1, 1'b1, 1'b1,
              p1, 2'd0, 2'd1, 1'b1, 1'b1};
   endfunction

   // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
   task automatic issue(input logic [2:0] code, input logic [4:0] iop,
                        input logic [9:0] asid, input logic [31:0] va);
      chk("ready_before_issue", op_ready, 1'b1);
      op_valid = 1'b1;
      op_code  = code;
      inv_op   = iop;
      inv_asid = asid;
      inv_va   = va;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   wcnt;
      int   dcnt;
      int   done_at;
      logic flush_seen;

      rst = 1'b1; op_valid = 1'b0; op_code = '0; inv_op = '0; inv_asid = '0; inv_va = '0;
      csr_tlbidx = '0; csr_tlbehi = '0; csr_tlbelo0 = '0; csr_tlbelo1 = '0; csr_asid = '0;
      csr_estat_ecode = '0; s_found = 1'b0; s_index = '0;
      for (int i = 0; i < TLBNUM; i++) pre_mem[i] = '0;
      pre_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      pre_en = 1'b0;

      chk("rst_ready", op_ready, 1'b1);
      chk("rst_done", op_done, 1'b0);
      chk("rst_we", we, 1'b0);
      chk("rst_tlbidx_wdata", tlbidx_wdata, 32'h0);
      rst = 1'b0;

      // FILL x3, round-robin from 0.
      csr_tlbidx  = 32'h0C00_0000;
      csr_tlbehi  = 32'h0040_2000;
      csr_tlbelo0 = 32'h0000_0113;
      csr_tlbelo1 = 32'h0000_0213;
      csr_asid    = 32'h0000_0003;
      for (int k = 0; k < 3; k++) begin
         issue(3'd3, 5'd0, 10'd0, 32'h0);
         chk("fill_done", op_done, 1'b1);
         chk("fill_we", we, 1'b1);
         chk("fill_index", w_index, k);
         chk("fill_entry", w_entry, mk(1'b1, 19'h00201, 6'd12, 10'd3, 1'b0, 20'h1, 20'h2));
         chk("fill_flush", tlb_flush, 1'b1);
         chk("fill_busy", op_ready, 1'b0);
         @(negedge clk);
      end

      // TLBRD of empty index 5.
      csr_tlbidx = 32'h0000_0005;
      issue(3'd1, 5'd0, 10'd0, 32'h0);
      chk("rd_empty_rindex", r_index, 4'd5);
      chk("rd_empty_we", rd_we, 1'b1);
      chk("rd_empty_idx", tlbidx_wdata, 32'h8000_0000);
      chk("rd_empty_ehi", tlbehi_wdata, 32'h0);
      chk("rd_empty_elo0", tlbelo0_wdata, 32'h0);
      chk("rd_empty_elo1", tlbelo1_wdata, 32'h0);
      chk("rd_empty_asid", asid_wdata, 32'h0);
      chk("rd_empty_tlbwe", we, 1'b0);
      @(negedge clk);

      // TLBRD of filled index 1.
      csr_tlbidx = 32'h0000_0001;
      issue(3'd1, 5'd0, 10'd0, 32'h0);
      chk("rd_full_idx", tlbidx_wdata, 32'h0C00_0001);
      chk("rd_full_ehi", tlbehi_wdata, 32'h0040_2000);
      chk("rd_full_elo0", tlbelo0_wdata, 32'h0000_0113);
      chk("rd_full_elo1", tlbelo1_wdata, 32'h0000_0213);
      chk("rd_full_asid", asid_wdata, 32'h0000_0003);
      @(negedge clk);

      // TLBSRCH hit and miss.
      csr_tlbidx = 32'h0C00_0003;
      s_found = 1'b1; s_index = 4'd7;
      issue(3'd0, 5'd0, 10'd0, 32'h0);
      chk("srch_hit_idx", tlbidx_wdata, 32'h0C00_0007);
      chk("srch_hit_we", srch_we, 1'b1);
      chk("srch_vppn", s_vppn, 19'h00201);
      chk("srch_asid", s_asid, 10'd3);
      chk("srch_rd_we", rd_we, 1'b0);
      @(negedge clk);
      s_found = 1'b0;
      issue(3'd0, 5'd0, 10'd0, 32'h0);
      chk("srch_miss_idx", tlbidx_wdata, 32'h8C00_0003);
      @(negedge clk);

      // TLBWR with NE=1: refill exception forces e=1, otherwise e=0.
      csr_tlbidx = 32'h8C00_0009; csr_estat_ecode = 6'h3F;
      issue(3'd2, 5'd0, 10'd0, 32'h0);
      chk("wr_tlbr_index", w_index, 4'd9);
      chk("wr_tlbr_entry", w_entry, mk(1'b1, 19'h00201, 6'd12, 10'd3, 1'b0, 20'h1, 20'h2));
      @(negedge clk);
      csr_tlbidx = 32'h8C00_000A; csr_estat_ecode = 6'h00;
      issue(3'd2, 5'd0, 10'd0, 32'h0);
      chk("wr_ne_index", w_index, 4'd10);
      chk("wr_ne_e", w_entry[88], 1'b0);
      chk("wr_ne_we", we, 1'b1);
      @(negedge clk);

      // INVTLB op 7 is INE.
      issue(3'd4, 5'd7, 10'd0, 32'h0);
      chk("inv7_done", op_done, 1'b1);
      chk("inv7_err", op_err, 1'b1);
      chk("inv7_we", we, 1'b0);
      @(negedge clk);

      // INVTLB op 5 over a mixed TLB: only 6 and 8 are g=0, asid=3, vppn=0x00201, e=1.
      for (int i = 0; i < TLBNUM; i++) begin
         pre_mem[i] = mk(i != 2, (i % 2 == 0) ? 19'h00201 : 19'h00300, 6'd12,
                         (i < 10) ? 10'd3 : 10'd7, (i == 0 || i == 4), 20'(i), 20'(i + 16));
         exp_mem[i] = pre_mem[i];
      end
      exp_mem[6][88] = 1'b0;
      exp_mem[8][88] = 1'b0;
      pre_en = 1'b1;
      @(negedge clk);
      pre_en = 1'b0;
      issue(3'd4, 5'd5, 10'd3, 32'h0040_2000);
      wcnt = 0; done_at = 0; flush_seen = 1'b0;
      for (int k = 1; k <= TLBNUM; k++) begin
         if (we) begin
            wcnt++;
            chk("inv5_wentry", w_entry, exp_mem[w_index]);
         end
         if (op_done && done_at == 0) begin
            done_at    = k;
            flush_seen = tlb_flush;
         end
         if (k < TLBNUM) @(negedge clk);
      end
      chk("inv5_done_cycle", done_at, 16);
      chk("inv5_flush", flush_seen, 1'b1);
      chk("inv5_wcount", wcnt, 2);
      @(negedge clk);
      chk("inv5_ready_after", op_ready, 1'b1);
      for (int i = 0; i < TLBNUM; i++) chk("inv5_mem", mem[i], exp_mem[i]);

      // Reset in the middle of an INVTLB op 0 walk (at i=4).
      issue(3'd4, 5'd0, 10'd0, 32'h0);
      chk("walk_i0_we", we, 1'b1);
      repeat (4) @(negedge clk);
      chk("walk_i4_rindex", r_index, 4'd4);
      rst = 1'b1;
      #1;
      chk("abort_we", we, 1'b0);
      chk("abort_done", op_done, 1'b0);
      @(negedge clk);
      chk("abort_ready", op_ready, 1'b1);
      rst = 1'b0;
      wcnt = 0; dcnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (we) wcnt++;
         if (op_done) dcnt++;
         @(negedge clk);
      end
      chk("abort_no_we", wcnt, 0);
      chk("abort_no_done", dcnt, 0);
      chk("abort_ent3_cleared", mem[3][88], 1'b0);
      chk("abort_ent4_kept", mem[4][88], 1'b1);

      // Fill pointer restarts at 0 after reset.
      issue(3'd3, 5'd0, 10'd0, 32'h0);
      chk("fill_after_rst_index", w_index, 4'd0);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
